// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage: data width, opcodes, FSM states.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 8;
    localparam int unsigned ALU_OP_W  = 3;

    localparam logic [ALU_OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [ALU_OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [ALU_OP_W-1:0] OP_AND  = 3'b010;
    localparam logic [ALU_OP_W-1:0] OP_OR   = 3'b011;
    localparam logic [ALU_OP_W-1:0] OP_XOR  = 3'b100;
    localparam logic [ALU_OP_W-1:0] OP_SLT  = 3'b101;
    localparam logic [ALU_OP_W-1:0] OP_MUL  = 3'b110;
    localparam logic [ALU_OP_W-1:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_exec_seq_mul8.sv
// Unsigned shift-add multiplier core: one partial product per step.
module seq_mul8 #(
    parameter int unsigned W     = 8,
    parameter int unsigned ITERS = W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [W-1:0]     mcand_i,
    input  logic [W-1:0]     mplier_i,
    output logic [2*W-1:0]   prod_o,
    output logic             finish_o
);

    localparam int unsigned CW = $clog2(ITERS + 1);

    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] acc_d;
    logic [CW-1:0]  cnt_q;

    // Accumulator value after the current step. Exposed directly so the final
    // step's product is usable in the same cycle it is formed.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    assign prod_o   = acc_d;
    assign finish_o = step_i && (cnt_q == CW'(ITERS - 1));

    // Load operands, then shift multiplicand left / multiplier right per step.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            mcand_q  <= {{W{1'b0}}, mcand_i};
            mplier_q <= mplier_i;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step_i) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Execute stage feeding the register file write port; single-cycle ops plus
// a sequential signed multiply with start/busy/done handshake.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = ALU_WIDTH,
    parameter int unsigned OP_W      = ALU_OP_W,
    parameter int unsigned MUL_ITERS = WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [OP_W-1:0]         op,
    input  logic [1:0]              wb_in,
    input  logic signed [WIDTH-1:0] src_a,
    input  logic signed [WIDTH-1:0] src_b,
    output logic                    busy,
    output logic                    done,
    output logic                    reg_en,
    output logic [1:0]              wb,
    output logic signed [WIDTH-1:0] result,
    output logic                    zero,
    output logic                    overflow
);

    localparam logic [2*WIDTH-1:0] HALF = (2*WIDTH)'(1) << (WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] result_q;
    logic [1:0]       wb_q;
    logic [1:0]       wb_pend_q;
    logic             zero_q;
    logic             ovf_q;
    logic             done_q;
    logic             sign_q;

    logic [WIDTH-1:0]   sum, diff, alu_res, mag_a, mag_b, mul_res;
    logic               alu_ovf, mul_ovf;
    logic               mul_load, mul_step, mul_fin;
    logic [2*WIDTH-1:0] mul_prod, mul_signed;

    // Single-cycle datapath evaluated on the live operands at acceptance.
    always_comb begin
        sum     = src_a + src_b;
        diff    = src_a - src_b;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SLT:  alu_res = WIDTH'(src_a < src_b);
            OP_PASS: alu_res = src_a;
            default: alu_res = '0;
        endcase
    end

    // Operand magnitudes for the multiplier (most negative value maps to 2^(W-1)).
    always_comb begin
        mag_a = src_a[WIDTH-1] ? (~src_a + WIDTH'(1)) : src_a;
        mag_b = src_b[WIDTH-1] ? (~src_b + WIDTH'(1)) : src_b;
    end

    assign mul_load = (state_q == ST_IDLE) && start && (op == OP_MUL);
    assign mul_step = (state_q == ST_MUL);

    seq_mul8 #(
        .W     (WIDTH),
        .ITERS (MUL_ITERS)
    ) u_mul (
        .clk_i    (clk),
        .rst_ni   (rst),
        .load_i   (mul_load),
        .step_i   (mul_step),
        .mcand_i  (mag_a),
        .mplier_i (mag_b),
        .prod_o   (mul_prod),
        .finish_o (mul_fin)
    );

    // Sign correction and range check on the finished magnitude product.
    always_comb begin
        mul_signed = sign_q ? (~mul_prod + (2*WIDTH)'(1)) : mul_prod;
        mul_res    = mul_signed[WIDTH-1:0];
        mul_ovf    = sign_q ? (mul_prod > HALF) : (mul_prod > (HALF - (2*WIDTH)'(1)));
    end

    // Control FSM with registered result, flags and completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            wb_q      <= '0;
            wb_pend_q <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            sign_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            wb_pend_q <= wb_in;
                            sign_q    <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
                            state_q   <= ST_MUL;
                        end else begin
                            result_q <= alu_res;
                            zero_q   <= (alu_res == '0);
                            ovf_q    <= alu_ovf;
                            wb_q     <= wb_in;
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_fin) begin
                        result_q <= mul_res;
                        zero_q   <= (mul_res == '0);
                        ovf_q    <= mul_ovf;
                        wb_q     <= wb_pend_q;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign reg_en   = done_q;
    assign wb       = wb_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec.
module tb_alu_exec;

    logic             clk;
    logic             rst;
    logic             start;
    logic [2:0]       op;
    logic [1:0]       wb_in;
    logic signed [7:0] src_a;
    logic signed [7:0] src_b;
    logic             busy;
    logic             done;
    logic             reg_en;
    logic [1:0]       wb;
    logic signed [7:0] result;
    logic             zero;
    logic             overflow;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc;

    alu_exec #(.WIDTH(8), .OP_W(3), .MUL_ITERS(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .wb_in    (wb_in),
        .src_a    (src_a),
        .src_b    (src_b),
        .busy     (busy),
        .done     (done),
        .reg_en   (reg_en),
        .wb       (wb),
        .result   (result),
        .zero     (zero),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input logic [1:0] w);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        wb_in = w;
    endtask

    // Issue a single-cycle op and check the completion cycle.
    task automatic alu_op(input string tag, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] w, input logic [7:0] exp_res, input logic exp_z, input logic exp_v);
        drive(o, a, b, w);
        tick();
        start = 1'b0;
        check({tag, "_done"}, {7'd0, done}, 8'd1);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_zero"}, {7'd0, zero}, {7'd0, exp_z});
        check({tag, "_ovf"}, {7'd0, overflow}, {7'd0, exp_v});
        tick();
        check({tag, "_idle"}, {7'd0, busy}, 8'd0);
    endtask

    // Issue a MUL, wait (bounded) for done, check latency and outputs.
    task automatic mul_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [1:0] w,
                          input logic [7:0] exp_res, input logic exp_z, input logic exp_v);
        int n;
        drive(3'b110, a, b, w);
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 8'(n), 8'd9);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_zero"}, {7'd0, zero}, {7'd0, exp_z});
        check({tag, "_ovf"}, {7'd0, overflow}, {7'd0, exp_v});
        check({tag, "_wb"}, {6'd0, wb}, {6'd0, w});
        tick();
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        op    = 3'b000;
        wb_in = 2'd0;
        src_a = 8'sd0;
        src_b = 8'sd0;
        tick();
        tick();
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_done", {7'd0, done}, 8'd0);
        check("rst_regen", {7'd0, reg_en}, 8'd0);
        check("rst_res", result, 8'd0);
        check("rst_wb", {6'd0, wb}, 8'd0);
        check("rst_zero", {7'd0, zero}, 8'd0);
        check("rst_ovf", {7'd0, overflow}, 8'd0);
        rst = 1'b1;
        tick();

        // ADD without and with signed overflow
        drive(3'b000, 8'd100, 8'd27, 2'd2);
        tick();
        start = 1'b0;
        check("add1_done", {7'd0, done}, 8'd1);
        check("add1_regen", {7'd0, reg_en}, 8'd1);
        check("add1_busy", {7'd0, busy}, 8'd1);
        check("add1_res", result, 8'd127);
        check("add1_ovf", {7'd0, overflow}, 8'd0);
        check("add1_wb", {6'd0, wb}, 8'd2);
        tick();
        check("add1_done_off", {7'd0, done}, 8'd0);
        check("add1_hold", result, 8'd127);
        alu_op("add2", 3'b000, 8'd100, 8'd28, 2'd1, 8'h80, 1'b0, 1'b1);
        check("add2_hold_ovf", {7'd0, overflow}, 8'd1);

        // SUB, SLT, logic ops and PASS
        alu_op("sub", 3'b001, 8'd5, 8'd5, 2'd1, 8'h00, 1'b1, 1'b0);
        alu_op("sub_ovf", 3'b001, 8'h80, 8'd1, 2'd1, 8'h7F, 1'b0, 1'b1);
        alu_op("slt1", 3'b101, 8'hFD, 8'd2, 2'd1, 8'h01, 1'b0, 1'b0);
        alu_op("slt2", 3'b101, 8'd2, 8'hFD, 2'd1, 8'h00, 1'b1, 1'b0);
        alu_op("and", 3'b010, 8'hF0, 8'h3C, 2'd1, 8'h30, 1'b0, 1'b0);
        alu_op("or", 3'b011, 8'hF0, 8'h0C, 2'd1, 8'hFC, 1'b0, 1'b0);
        alu_op("xor", 3'b100, 8'hFF, 8'h0F, 2'd1, 8'hF0, 1'b0, 1'b0);
        alu_op("add3", 3'b000, 8'h7F, 8'd1, 2'd0, 8'h80, 1'b0, 1'b1);
        alu_op("pass", 3'b111, 8'h80, 8'h7F, 2'd3, 8'h80, 1'b0, 1'b0);

        // MUL -7*6 with start pulses during MUL (cycle 4) and DONE (cycle 9)
        drive(3'b110, 8'hF9, 8'd6, 2'd3);
        tick();
        for (int c = 1; c <= 8; c++) begin
            if (c == 4) drive(3'b000, 8'd1, 8'd1, 2'd0);
            else start = 1'b0;
            check("mul_busy", {7'd0, busy}, 8'd1);
            check("mul_nodone", {7'd0, done}, 8'd0);
            tick();
        end
        drive(3'b000, 8'd1, 8'd1, 2'd0);
        check("mul_done", {7'd0, done}, 8'd1);
        check("mul_regen", {7'd0, reg_en}, 8'd1);
        check("mul_busy9", {7'd0, busy}, 8'd1);
        check("mul_res", result, 8'hD6);
        check("mul_ovf", {7'd0, overflow}, 8'd0);
        check("mul_wb", {6'd0, wb}, 8'd3);
        tick();
        start = 1'b0;
        cyc = 0;
        for (int c = 0; c < 4; c++) begin
            if (reg_en || busy) cyc++;
            tick();
        end
        check("mul_no_second", 8'(cyc), 8'd0);
        check("mul_res_hold", result, 8'hD6);

        mul_op("mul16", 8'd16, 8'd16, 2'd2, 8'h00, 1'b1, 1'b1);
        mul_op("mulm128", 8'h80, 8'd1, 2'd1, 8'h80, 1'b0, 1'b0);
        mul_op("mulm128n", 8'h80, 8'hFF, 2'd0, 8'h80, 1'b0, 1'b1);
        mul_op("mulnn", 8'hF5, 8'hF5, 2'd3, 8'h79, 1'b0, 1'b0);

        // Reset mid-MUL at cycle 5
        drive(3'b110, 8'd3, 8'd3, 2'd2);
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        #1;
        check("mrst_busy", {7'd0, busy}, 8'd0);
        check("mrst_done", {7'd0, done}, 8'd0);
        check("mrst_res", result, 8'd0);
        check("mrst_wb", {6'd0, wb}, 8'd0);
        check("mrst_ovf", {7'd0, overflow}, 8'd0);
        check("mrst_zero", {7'd0, zero}, 8'd0);
        cyc = 0;
        for (int c = 0; c < 6; c++) begin
            if (reg_en) cyc++;
            tick();
        end
        check("mrst_no_regen", 8'(cyc), 8'd0);
        rst = 1'b1;
        tick();
        cyc = 0;
        for (int c = 0; c < 10; c++) begin
            if (reg_en) cyc++;
            tick();
        end
        check("mrst_release_no_regen", 8'(cyc), 8'd0);
        alu_op("post_add", 3'b000, 8'd1, 8'd1, 2'd1, 8'd2, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
